// File: rtl/mtimer_avmm.sv
// Multi-channel down-counting timer on an Avalon-MM slave, one shared level interrupt.
// Define MTIMER_PRESCALE_EN to add a per-channel 8-bit tick prescaler in CTRL[15:8].
//
// state   | meaning
// ST_IDLE | channel stopped, counter holds 0
// ST_RUN  | channel counting down on each tick (busy)
module mtimer_avmm #(
  parameter int N_CH            = 4,
  parameter int CNT_W           = 64,
  parameter int FREQUENCY_VALUE = 50_000_000,
  localparam int AW             = $clog2(N_CH) + 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] avmms_address,
  input  logic          avmms_write,
  input  logic [31:0]   avmms_writedata,
  input  logic [3:0]    avmms_byteenable,
  input  logic          avmms_read,
  output logic [31:0]   avmms_readdata,
  output logic          coe_interrupt
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} st_e;

  st_e              st_q   [N_CH];
  st_e              st_d   [N_CH];
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [CNT_W-1:0] load_q [N_CH];
  logic [CNT_W-1:0] load_d [N_CH];
  logic [N_CH-1:0]  periodic_q, periodic_d;
  logic [N_CH-1:0]  irq_en_q, irq_en_d;
  logic [N_CH-1:0]  complete_q, complete_d;
  logic [N_CH-1:0]  overrun_q, overrun_d;
  logic [N_CH-1:0]  start_pend_q, start_pend_d;
  logic [N_CH-1:0]  stop_pend_q, stop_pend_d;
  logic [31:0]      rdata_q, rdata_d;
`ifdef MTIMER_PRESCALE_EN
  logic [7:0]       ps_val_q [N_CH];
  logic [7:0]       ps_val_d [N_CH];
  logic [7:0]       ps_cnt_q [N_CH];
  logic [7:0]       ps_cnt_d [N_CH];
`endif

  logic [AW-1:0] ch_addr;
  logic [1:0]    reg_addr;

  assign ch_addr  = avmms_address >> 2;
  assign reg_addr = avmms_address[1:0];

  always_comb begin
    rdata_d      = rdata_q;
    periodic_d   = periodic_q;
    irq_en_d     = irq_en_q;
    complete_d   = complete_q;
    overrun_d    = overrun_q;
    start_pend_d = '0;
    stop_pend_d  = '0;
    if (avmms_read) rdata_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      logic        sel;
      logic        wr;
      logic        tick;
      logic [63:0] ld_cur;
      logic [63:0] ld_new;
      logic [7:0]  ps_rd;
      sel    = (ch_addr == AW'(c));
      wr     = avmms_write && sel;
      ld_cur = 64'(load_q[c]);
      ld_new = ld_cur;
      st_d[c]  = st_q[c];
      cnt_d[c] = cnt_q[c];
      ps_rd    = 8'h00;

      for (int b = 0; b < 4; b++) begin
        if (wr && avmms_byteenable[b]) begin
          if (reg_addr == 2'd1) ld_new[8*b +: 8]      = avmms_writedata[8*b +: 8];
          if (reg_addr == 2'd2) ld_new[32 + 8*b +: 8] = avmms_writedata[8*b +: 8];
        end
      end
      load_d[c] = CNT_W'(ld_new);

      if (wr && reg_addr == 2'd0 && avmms_byteenable[0]) begin
        start_pend_d[c] = avmms_writedata[0];
        stop_pend_d[c]  = avmms_writedata[1];
        periodic_d[c]   = avmms_writedata[2];
        irq_en_d[c]     = avmms_writedata[3];
        if (avmms_writedata[5]) complete_d[c] = 1'b0;
        if (avmms_writedata[6]) overrun_d[c]  = 1'b0;
      end

`ifdef MTIMER_PRESCALE_EN
      ps_val_d[c] = ps_val_q[c];
      ps_rd       = ps_val_q[c];
      if (wr && reg_addr == 2'd0 && avmms_byteenable[1]) ps_val_d[c] = avmms_writedata[15:8];
      tick        = (ps_cnt_q[c] == ps_val_q[c]);
      ps_cnt_d[c] = tick ? 8'h00 : ps_cnt_q[c] + 8'h01;
      if (start_pend_q[c] || stop_pend_q[c]) ps_cnt_d[c] = 8'h00;
`else
      tick = 1'b1;
`endif

      // Commands are acted on one edge after the write; start beats stop.
      if (start_pend_q[c] && load_q[c] != '0) begin
        cnt_d[c] = load_q[c];
        st_d[c]  = ST_RUN;
      end else if (stop_pend_q[c]) begin
        cnt_d[c] = '0;
        st_d[c]  = ST_IDLE;
      end else if (st_q[c] == ST_RUN && tick) begin
        if (cnt_q[c] == CNT_W'(1)) begin
          complete_d[c] = 1'b1;
          if (complete_q[c]) overrun_d[c] = 1'b1;
          if (periodic_q[c] && load_q[c] != '0) begin
            cnt_d[c] = load_q[c];
          end else begin
            cnt_d[c] = '0;
            st_d[c]  = ST_IDLE;
          end
        end else if (cnt_q[c] != '0) begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end
      end

      if (avmms_read && sel) begin
        case (reg_addr)
          2'd0: rdata_d = {16'h0000, ps_rd, 1'b0, overrun_q[c], complete_q[c],
                           (st_q[c] == ST_RUN), irq_en_q[c], periodic_q[c], 2'b00};
          2'd1: rdata_d = ld_cur[31:0];
          2'd2: rdata_d = ld_cur[63:32];
          default: rdata_d = 32'(cnt_q[c]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q      <= '0;
      periodic_q   <= '0;
      irq_en_q     <= '0;
      complete_q   <= '0;
      overrun_q    <= '0;
      start_pend_q <= '0;
      stop_pend_q  <= '0;
      for (int c = 0; c < N_CH; c++) begin
        st_q[c]   <= ST_IDLE;
        cnt_q[c]  <= '0;
        load_q[c] <= '0;
`ifdef MTIMER_PRESCALE_EN
        ps_val_q[c] <= '0;
        ps_cnt_q[c] <= '0;
`endif
      end
    end else begin
      rdata_q      <= rdata_d;
      periodic_q   <= periodic_d;
      irq_en_q     <= irq_en_d;
      complete_q   <= complete_d;
      overrun_q    <= overrun_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
      for (int c = 0; c < N_CH; c++) begin
        st_q[c]   <= st_d[c];
        cnt_q[c]  <= cnt_d[c];
        load_q[c] <= load_d[c];
`ifdef MTIMER_PRESCALE_EN
        ps_val_q[c] <= ps_val_d[c];
        ps_cnt_q[c] <= ps_cnt_d[c];
`endif
      end
    end
  end

  assign avmms_readdata = rdata_q;
  assign coe_interrupt  = |(complete_q & irq_en_q);

endmodule

// File: doc/mtimer_avmm.md
# mtimer_avmm

Multi-channel down-counting timer with an Avalon-MM slave register interface and one shared level interrupt. It generalises the single one-shot timer to N_CH independent channels with a configurable counter width, one-shot or periodic reload, per-channel interrupt enable and an overrun flag. It sits on the system Avalon-MM interconnect next to the other memory-mapped peripherals; software uses it for timeouts and periodic ticks.

## Interface
- N_CH, 4, number of channels (1..16)
- CNT_W, 64, counter width in bits (1..64)
- FREQUENCY_VALUE, 50_000_000, clk frequency in Hz; informational only, no effect on logic
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- avmms_address  in  $clog2(N_CH)+2  word address; upper bits select the channel, [1:0] select the register
- avmms_write  in  1  write strobe
- avmms_writedata  in  32  write data
- avmms_byteenable  in  4  byte lanes for writedata
- avmms_read  in  1  read strobe
- avmms_readdata  out  32  read data, registered
- coe_interrupt  out  1  level interrupt: OR over channels of (complete & irq_en)

## Operation
- Per-channel registers (word offset):
  - 0 CTRL/STATUS: bit0 start (W, pulse), bit1 stop (W, pulse), bit2 periodic (RW), bit3 irq_en (RW), bit4 busy (RO), bit5 complete (W1C), bit6 overrun (W1C). All other bits read 0. Bits 0..6 are written only when byteenable[0]=1.
  - 1 LOAD_LO: load[31:0], RW, byte-enabled.
  - 2 LOAD_HI: load[63:32], RW, byte-enabled.
  - 3 COUNT: live counter[31:0], RO; writes ignored.
- Load bits at or above CNT_W are not stored and read 0. Counter arithmetic is modulo 2^CNT_W and never wraps below 0.
- Start with load>0: counter<=load, busy<=1. Start with load==0 is ignored.
- Start and stop written together: start wins.
- Stop: counter<=0, busy<=0. complete and overrun are unchanged.
- While busy, the counter decrements by 1 on each tick.
- Expiry (counter==1 on a tick):
  - complete<=1.
  - If complete is already 1, overrun<=1.
  - Periodic with load>0: counter<=load and busy stays 1.
  - Otherwise: counter<=0 and busy<=0.
- A W1C clear that coincides with expiry: the set wins.
- Start while busy restarts the count from the current load.
- Writing LOAD while busy takes effect only at the next start or periodic reload.

## Timing
- Reset values: all counters, load, flags and control bits are 0; avmms_readdata=0; coe_interrupt=0.
- Write accepted at edge E0. Start/stop take effect at edge E1, the next edge.
- A one-shot with load L and no prescale:
  - busy rises at E1;
  - complete rises L edges after E1;
  - busy falls on that same edge.
- Periodic mode sets complete every L cycles.
- Read latency is 1 cycle: avmms_readdata is valid in the cycle after avmms_read. It holds its value when no read is issued.
- coe_interrupt is a combinational OR of registered bits, so it moves in the same cycle as complete or irq_en.
- Asynchronous reset mid-count returns every channel to idle immediately.

## Configuration
- MTIMER_PRESCALE_EN defined:
  - CTRL bits[15:8] become a per-channel RW prescale value P (written under byteenable[1]).
  - A tick occurs once every P+1 clk cycles.
  - The prescale counter restarts on start and on stop.
- MTIMER_PRESCALE_EN undefined: bits[15:8] read 0 and a tick occurs every clk cycle.

## Test plan
- Channel 0, LOAD_LO=5, write CTRL=0x9 (start+irq_en) -> busy=1 at E1; complete=1 and coe_interrupt=1 exactly 5 cycles later; COUNT reads 0.
- Channel 1, LOAD=3, periodic, start -> complete at +3. Leave complete uncleared until +6 -> overrun=1. Writing CTRL=0x60 clears both flags; busy stays 1.
- Channel 2, LOAD=0x1_0000_0000 (LOAD_HI=1, CNT_W=64), start; stop after 10 cycles -> COUNT=0, busy=0, complete=0.
- Start with load=0 -> busy stays 0. Start+stop in the same write with LOAD=4 -> busy=1 and counter=4.
- Channels 0 and 3 running, only channel 3 with irq_en=1 -> coe_interrupt follows channel 3's complete only.
- Assert reset_n low mid-count -> all readbacks 0 and coe_interrupt=0 immediately. With MTIMER_PRESCALE_EN, P=3, LOAD=2 -> complete 8 cycles after E1.
